// File: rtl/snn_if_pkg.sv
// Shared spike-interface definitions: widths, sentinel time, receiver FSM states and event record.
package snn_if_pkg;

  localparam int TIME_W     = 32;
  localparam int FLAT_LEN   = 320;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = $clog2(FLAT_LEN);
  localparam int CNT_W      = $clog2(FLAT_LEN + 1);

  localparam logic [TIME_W-1:0] TIME_NONE  = 32'h7FFF_FFFF;
  localparam logic [ADDR_W-1:0] FLAT_LEN_A = ADDR_W'(FLAT_LEN);
  localparam logic [CNT_W-1:0]  FLAT_LEN_C = CNT_W'(FLAT_LEN);

  typedef enum logic [1:0] {
    S_RECV  = 2'd0,
    S_DRAIN = 2'd1,
    S_READY = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic signed [TIME_W-1:0] t;
    logic [ADDR_W-1:0]        addr;
  } spike_evt_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (a < FLAT_LEN_A);
  endfunction

endpackage

// File: rtl/spike_rx_fifo.sv
// Small synchronous FIFO for ingress spike events; push and pop may happen in the same cycle.
module spike_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/spike_event_receiver.sv
// Spike stream receiver: valid/ack ingress, FIFO, per-address spike-time RAM, frame FSM.
// Optional duplicate-address flag o_err_dup when SPIKE_RX_DUP_CHECK_EN is defined.
module spike_event_receiver
  import snn_if_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_spike_valid,
  output logic                     o_spike_ack,
  input  logic signed [TIME_W-1:0] i_spike_time,
  input  logic [ADDR_W-1:0]        i_spike_addr,
  input  logic                     i_cnn_done,
  output logic                     o_frame_done,
  output logic                     o_frame_ready,
  input  logic                     i_frame_release,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  output logic [TIME_W-1:0]        o_rd_time,
  output logic [CNT_W-1:0]         o_spike_count,
`ifdef SPIKE_RX_DUP_CHECK_EN
  output logic                     o_err_dup,
`endif
  output logic                     o_err_addr
);

  rx_state_e         state_q, state_d;
  logic              ack_q, ack_d;
  logic              frame_done_q, frame_done_d;
  logic              release_clr;
  logic              fifo_full, fifo_empty;
  spike_evt_t        push_evt, head_evt;
  logic              retire;
  logic              head_in_range;
  logic [FLAT_LEN-1:0] bitmap_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_addr_q;
  logic [TIME_W-1:0] ram [FLAT_LEN];
  logic [TIME_W-1:0] ram_rd_q;
  logic              hit_q;
  logic              rd_vld_q;

  // Gap after every ack gives the sender a cycle to present the next event.
  assign ack_d    = i_spike_valid && (state_q != S_READY) && !fifo_full && !ack_q;
  assign push_evt = '{t: i_spike_time, addr: i_spike_addr};
  assign retire   = !fifo_empty;
  assign head_in_range = addr_in_range(head_evt.addr);

  spike_rx_fifo #(
    .W     ($bits(spike_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (ack_q),
    .wr_data_i (push_evt),
    .pop_i     (retire),
    .rd_data_o (head_evt),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    release_clr  = 1'b0;
    case (state_q)
      S_RECV:  if (i_cnn_done) state_d = S_DRAIN;
      S_DRAIN: begin
        if (fifo_empty && !ack_q && !ack_d) begin
          state_d      = S_READY;
          frame_done_d = 1'b1;
        end
      end
      S_READY: begin
        if (i_frame_release) begin
          state_d     = S_RECV;
          release_clr = 1'b1;
        end
      end
      default: state_d = S_RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RECV;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q   <= '0;
      count_q    <= '0;
      err_addr_q <= 1'b0;
    end else if (release_clr) begin
      bitmap_q   <= '0;
      count_q    <= '0;
      err_addr_q <= 1'b0;
    end else if (retire) begin
      if (head_in_range) begin
        bitmap_q[head_evt.addr] <= 1'b1;
        if (count_q < FLAT_LEN_C) count_q <= count_q + 1'b1;
      end else begin
        err_addr_q <= 1'b1;
      end
    end
  end

`ifdef SPIKE_RX_DUP_CHECK_EN
  logic err_dup_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_dup_q <= 1'b0;
    end else if (release_clr) begin
      err_dup_q <= 1'b0;
    end else if (retire && head_in_range && bitmap_q[head_evt.addr]) begin
      err_dup_q <= 1'b1;
    end
  end

  assign o_err_dup = err_dup_q;
`endif

  // Simple dual-port spike-time RAM; validity comes from the bitmap, so no clear is needed.
  always_ff @(posedge clk) begin
    if (retire && head_in_range) ram[head_evt.addr] <= head_evt.t;
    ram_rd_q <= ram[i_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      hit_q    <= addr_in_range(i_rd_addr) && bitmap_q[i_rd_addr];
      rd_vld_q <= 1'b1;
    end
  end

  assign o_rd_time     = !rd_vld_q ? '0 : (hit_q ? ram_rd_q : TIME_NONE);
  assign o_spike_ack   = ack_q;
  assign o_frame_done  = frame_done_q;
  assign o_frame_ready = (state_q == S_READY);
  assign o_spike_count = count_q;
  assign o_err_addr    = err_addr_q;

endmodule

// File: tb/tb_spike_event_receiver.sv
// Directed bench for spike_event_receiver: single event, full burst, stall, bad address, duplicate, reset.
module tb_spike_event_receiver;
  import snn_if_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     i_spike_valid = 1'b0;
  logic                     o_spike_ack;
  logic signed [TIME_W-1:0] i_spike_time = '0;
  logic [ADDR_W-1:0]        i_spike_addr = '0;
  logic                     i_cnn_done = 1'b0;
  logic                     o_frame_done;
  logic                     o_frame_ready;
  logic                     i_frame_release = 1'b0;
  logic [ADDR_W-1:0]        i_rd_addr = '0;
  logic [TIME_W-1:0]        o_rd_time;
  logic [CNT_W-1:0]         o_spike_count;
  logic                     o_err_addr;
`ifdef SPIKE_RX_DUP_CHECK_EN
  logic                     o_err_dup;
`endif

  int errors = 0;
  int checks = 0;
  int ack_total = 0;
  int ack_b2b = 0;
  logic ack_prev = 1'b0;
  int a0;
  logic got;

  always #5 clk = ~clk;

  spike_event_receiver dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_spike_valid   (i_spike_valid),
    .o_spike_ack     (o_spike_ack),
    .i_spike_time    (i_spike_time),
    .i_spike_addr    (i_spike_addr),
    .i_cnn_done      (i_cnn_done),
    .o_frame_done    (o_frame_done),
    .o_frame_ready   (o_frame_ready),
    .i_frame_release (i_frame_release),
    .i_rd_addr       (i_rd_addr),
    .o_rd_time       (o_rd_time),
    .o_spike_count   (o_spike_count),
`ifdef SPIKE_RX_DUP_CHECK_EN
    .o_err_dup       (o_err_dup),
`endif
    .o_err_addr      (o_err_addr)
  );

  always @(posedge clk) begin
    if (o_spike_ack && ack_prev) ack_b2b++;
    if (o_spike_ack) ack_total++;
    ack_prev = o_spike_ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one event, wait for its ack, hold data through the capture edge.
  task automatic send_evt(input int t, input int a, input logic quiet);
    logic seen;
    i_spike_time  = TIME_W'(t);
    i_spike_addr  = ADDR_W'(a);
    i_spike_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (o_spike_ack) seen = 1'b1;
    end
    check("ack_seen", 32'(seen), 32'd1);
    tick();
    i_spike_valid = 1'b0;
    if (!quiet) $display("evt time=%0d addr=%0d acked=%0d", t, a, seen);
  endtask

  task automatic pulse_done();
    i_cnn_done = 1'b1;
    tick();
    i_cnn_done = 1'b0;
  endtask

  task automatic pulse_release();
    i_frame_release = 1'b1;
    tick();
    i_frame_release = 1'b0;
    $display("frame release");
  endtask

  task automatic wait_frame_done();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (o_frame_done) seen = 1'b1;
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    check("frame_ready_at_done", 32'(o_frame_ready), 32'd1);
    tick();
    check("frame_done_one_cycle", 32'(o_frame_done), 32'd0);
    $display("frame done count=%0d", o_spike_count);
  endtask

  task automatic rd(input string tag, input int a, input logic [31:0] exp);
    i_rd_addr = ADDR_W'(a);
    tick();
    check(tag, o_rd_time, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   32'(o_spike_ack),   32'd0);
    check({tag, "_done"},  32'(o_frame_done),  32'd0);
    check({tag, "_ready"}, 32'(o_frame_ready), 32'd0);
    check({tag, "_rd"},    o_rd_time,          32'd0);
    check({tag, "_count"}, 32'(o_spike_count), 32'd0);
    check({tag, "_erra"},  32'(o_err_addr),    32'd0);
`ifdef SPIKE_RX_DUP_CHECK_EN
    check({tag, "_errd"},  32'(o_err_dup),     32'd0);
`endif
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: single event
    a0 = ack_total;
    send_evt(5, 7, 1'b0);
    pulse_done();
    wait_frame_done();
    check("t1_ack_count", 32'(ack_total - a0), 32'd1);
    check("t1_count", 32'(o_spike_count), 32'd1);
    rd("t1_rd7", 7, 32'd5);
    rd("t1_rd8", 8, TIME_NONE);
    pulse_release();
    check("t1_ready_cleared", 32'(o_frame_ready), 32'd0);
    check("t1_count_cleared", 32'(o_spike_count), 32'd0);
    rd("t1_rd7_after_release", 7, TIME_NONE);

    // 2: full burst, valid held continuously
    ack_b2b = 0;
    for (int i = 0; i < FLAT_LEN; i++) send_evt(i * 3, i, 1'b1);
    $display("burst of %0d events sent", FLAT_LEN);
    pulse_done();
    wait_frame_done();
    check("t2_no_b2b_ack", 32'(ack_b2b), 32'd0);
    check("t2_count", 32'(o_spike_count), 32'd320);
    for (int i = 0; i < FLAT_LEN; i++) rd("t2_rd", i, 32'(i * 3));
    rd("t2_rd320", 320, TIME_NONE);
    rd("t2_rd511", 511, TIME_NONE);

    // 3: stall while frame is held in S_READY
    i_spike_time  = 32'sd77;
    i_spike_addr  = ADDR_W'(2);
    i_spike_valid = 1'b1;
    a0 = ack_total;
    repeat (10) tick();
    check("t3_stall_no_ack", 32'(ack_total - a0), 32'd0);
    pulse_release();
    check("t3_count_after_release", 32'(o_spike_count), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (o_spike_ack) got = 1'b1;
    end
    check("t3_ack_after_release", 32'(got), 32'd1);
    tick();
    i_spike_valid = 1'b0;
    $display("evt time=77 addr=2 acked=%0d", got);
    pulse_done();
    wait_frame_done();
    check("t3_count", 32'(o_spike_count), 32'd1);
    rd("t3_rd2", 2, 32'd77);
    rd("t3_rd5_old_frame", 5, TIME_NONE);
    pulse_release();

    // 4: out-of-range address
    send_evt(9, 400, 1'b0);
    repeat (3) tick();
    check("t4_err_addr", 32'(o_err_addr), 32'd1);
    check("t4_count", 32'(o_spike_count), 32'd0);
    pulse_done();
    wait_frame_done();
    check("t4_err_addr_held", 32'(o_err_addr), 32'd1);
    rd("t4_rd400", 400, TIME_NONE);
    pulse_release();
    check("t4_err_addr_cleared", 32'(o_err_addr), 32'd0);

    // 5: duplicate address, last write wins
    send_evt(10, 3, 1'b0);
    send_evt(20, 3, 1'b0);
    pulse_done();
    wait_frame_done();
    rd("t5_rd3", 3, 32'd20);
    check("t5_count", 32'(o_spike_count), 32'd2);
`ifdef SPIKE_RX_DUP_CHECK_EN
    check("t5_err_dup", 32'(o_err_dup), 32'd1);
`endif
    pulse_release();
`ifdef SPIKE_RX_DUP_CHECK_EN
    check("t5_err_dup_cleared", 32'(o_err_dup), 32'd0);
`endif
    rd("t5_rd3_after_release", 3, TIME_NONE);

    // 6: reset mid-frame
    send_evt(11, 1, 1'b0);
    send_evt(9, 400, 1'b0);
    send_evt(12, 4, 1'b0);
    check("t6_err_before_reset", 32'(o_err_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("reset mid-frame");
    rd("t6_rd1", 1, TIME_NONE);
    rd("t6_rd4", 4, TIME_NONE);
    check("t6_ready", 32'(o_frame_ready), 32'd0);
    check("t6_count", 32'(o_spike_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
